cpu_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit core. Sequences each instruction through

---
 rtl/cpu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control FSM for the 8-bit core. Each instruction moves through
//   FETCH -> DECODE -> EXECUTE -> WRITEBACK. The FSM gates the decoder's ALU and
//   register-write enables into the datapath, and drives the PC advance/load
//   strobes for sequential flow and conditional branches. It also handles HALT,
//   board single-step, and a saturating retired-instruction counter.
//
//   State | Meaning
//   ------+---------------------------------------------------------------
//   IDLE  | one cycle after reset release, then FETCH
//   FETCH | ir_load pulse, ROM word into the instruction register
//   DECODE| decode inputs latched; HALT is detected here
//   EXEC  | alu_en from the latched decode; flags captured for ALU ops
//   WB    | write_en, pc_en, pc_overwrite on a taken branch; retire count
//   STEP  | single-step park; a step_pulse starts the next fetch
//   HALTED| core stopped; resume_pulse gives one skip cycle (pc_en) then FETCH
//
// Ports
//   i_clk, i_rst_n                 system clock, async active-low reset
//   i_dec_alu_en, i_dec_write_en   decoder enables (latched in DECODE)
//   i_dec_halt                     decoder HALT indication (used in DECODE)
//   i_dec_br_op[1:0]               00 none, 01 JMP, 10 JZ, 11 JC
//   i_alu_zero, i_alu_carry        datapath flags, valid during EXECUTE
//   i_step_mode                    1 = park in STEP_WAIT after every instruction
//   i_step_pulse, i_resume_pulse   single-cycle board pulses
//   o_ir_load, o_alu_en, o_write_en, o_pc_en, o_pc_overwrite   datapath strobes
//   o_halted                       core is in HALTED
//   o_state[2:0]                   current state code (debug)
//   o_retired[CNT_W-1:0]           retired instruction count, saturating
// ----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_dec_alu_en,
    input  logic             i_dec_write_en,
    input  logic             i_dec_halt,
    input  logic [1:0]       i_dec_br_op,
    input  logic             i_alu_zero,
    input  logic             i_alu_carry,
    input  logic             i_step_mode,
    input  logic             i_step_pulse,
    input  logic             i_resume_pulse,
    output logic             o_ir_load,
    output logic             o_alu_en,
    output logic             o_write_en,
    output logic             o_pc_en,
    output logic             o_pc_overwrite,
    output logic             o_halted,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_STEP_WAIT = 3'd5,
        S_HALTED    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic             r_alu_en_l;
    logic             r_write_en_l;
    logic [1:0]       r_br_op_l;
    logic             r_flag_z;
    logic             r_flag_c;
    logic             r_resume;
    logic             w_resume_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_taken;

    // Branches test the flags of the most recent ALU instruction, never the
    // live datapath flags.
    assign w_taken = (r_br_op_l == 2'b01) ||
                     ((r_br_op_l == 2'b10) && r_flag_z) ||
                     ((r_br_op_l == 2'b11) && r_flag_c);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_alu_en_l   <= 1'b0;
            r_write_en_l <= 1'b0;
            r_br_op_l    <= 2'b00;
            r_flag_z     <= 1'b0;
            r_flag_c     <= 1'b0;
            r_resume     <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_resume <= w_resume_next;
            if (r_state == S_DECODE) begin
                r_alu_en_l   <= i_dec_alu_en;
                r_write_en_l <= i_dec_write_en;
                r_br_op_l    <= i_dec_br_op;
            end
            if ((r_state == S_EXECUTE) && r_alu_en_l) begin
                r_flag_z <= i_alu_zero;
                r_flag_c <= i_alu_carry;
            end
            if ((r_state == S_WRITEBACK) && (r_retired != CNT_MAX)) begin
                r_retired <= r_retired + CNT_ONE;
            end
        end
    end

    // Next-state logic. The resume request is registered so the skip-past-HALT
    // pc_en is a clean state-decoded strobe rather than a copy of the pulse.
    always_comb begin
        w_next_state  = r_state;
        w_resume_next = 1'b0;
        case (r_state)
            S_IDLE:      w_next_state = S_FETCH;
            S_FETCH:     w_next_state = S_DECODE;
            S_DECODE:    w_next_state = i_dec_halt ? S_HALTED : S_EXECUTE;
            S_EXECUTE:   w_next_state = S_WRITEBACK;
            S_WRITEBACK: w_next_state = i_step_mode ? S_STEP_WAIT : S_FETCH;
            S_STEP_WAIT: begin
                if (i_step_pulse) begin
                    w_next_state = S_FETCH;
                end
            end
            S_HALTED: begin
                if (r_resume) begin
                    w_next_state = S_FETCH;
                end else if (i_resume_pulse) begin
                    w_resume_next = 1'b1;
                end
            end
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_ir_load      = 1'b0;
        o_alu_en       = 1'b0;
        o_write_en     = 1'b0;
        o_pc_en        = 1'b0;
        o_pc_overwrite = 1'b0;
        o_halted       = 1'b0;
        case (r_state)
            S_FETCH:     o_ir_load = 1'b1;
            S_EXECUTE:   o_alu_en  = r_alu_en_l;
            S_WRITEBACK: begin
                o_write_en     = r_write_en_l;
                o_pc_en        = 1'b1;
                o_pc_overwrite = w_taken;
            end
            S_HALTED: begin
                o_halted = 1'b1;
                o_pc_en  = r_resume;
            end
            default: ;
        endcase
    end

    assign o_state   = r_state;
    assign o_retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer. A second instance with a 4-bit counter
//   shares all inputs so counter saturation is observed alongside the main run.
// ----------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_alu_en, dec_write_en, dec_halt;
    logic [1:0]  dec_br_op;
    logic        alu_zero, alu_carry;
    logic        step_mode, step_pulse, resume_pulse;

    logic        ir_load, alu_en, write_en, pc_en, pc_overwrite, halted;
    logic [2:0]  state;
    logic [15:0] retired;

    logic        w4_ir_load, w4_alu_en, w4_write_en, w4_pc_en, w4_pc_overwrite, w4_halted;
    logic [2:0]  w4_state;
    logic [3:0]  w4_retired;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_dec_alu_en(dec_alu_en), .i_dec_write_en(dec_write_en),
        .i_dec_halt(dec_halt), .i_dec_br_op(dec_br_op),
        .i_alu_zero(alu_zero), .i_alu_carry(alu_carry),
        .i_step_mode(step_mode), .i_step_pulse(step_pulse),
        .i_resume_pulse(resume_pulse),
        .o_ir_load(ir_load), .o_alu_en(alu_en), .o_write_en(write_en),
        .o_pc_en(pc_en), .o_pc_overwrite(pc_overwrite), .o_halted(halted),
        .o_state(state), .o_retired(retired)
    );

    cpu_sequencer #(.CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_dec_alu_en(dec_alu_en), .i_dec_write_en(dec_write_en),
        .i_dec_halt(dec_halt), .i_dec_br_op(dec_br_op),
        .i_alu_zero(alu_zero), .i_alu_carry(alu_carry),
        .i_step_mode(step_mode), .i_step_pulse(step_pulse),
        .i_resume_pulse(resume_pulse),
        .o_ir_load(w4_ir_load), .o_alu_en(w4_alu_en), .o_write_en(w4_write_en),
        .o_pc_en(w4_pc_en), .o_pc_overwrite(w4_pc_overwrite), .o_halted(w4_halted),
        .o_state(w4_state), .o_retired(w4_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one non-HALT instruction starting from a sampled FETCH cycle and
    // returns sampled in its WRITEBACK cycle.
    task automatic run_instr(input string tag, input logic alu, input logic wr,
                             input logic [1:0] br, input logic z, input logic c,
                             input logic exp_ovr, input logic pulse_in_exec);
        chk({tag, ".fetch_state"}, 32'(state), 32'd1);
        chk({tag, ".ir_load"}, 32'(ir_load), 32'd1);
        dec_alu_en = alu; dec_write_en = wr; dec_halt = 1'b0; dec_br_op = br;
        alu_zero = z; alu_carry = c;
        tick();
        chk({tag, ".decode_state"}, 32'(state), 32'd2);
        chk({tag, ".decode_strobes"}, {28'd0, ir_load, alu_en, write_en, pc_en}, 32'd0);
        tick();
        chk({tag, ".exec_state"}, 32'(state), 32'd3);
        chk({tag, ".exec_alu_en"}, 32'(alu_en), 32'(alu));
        chk({tag, ".exec_other"}, {29'd0, ir_load, write_en, pc_en}, 32'd0);
        if (pulse_in_exec) step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        chk({tag, ".wb_state"}, 32'(state), 32'd4);
        chk({tag, ".wb_pc_en"}, 32'(pc_en), 32'd1);
        chk({tag, ".wb_write_en"}, 32'(write_en), 32'(wr));
        chk({tag, ".wb_overwrite"}, 32'(pc_overwrite), 32'(exp_ovr));
        chk({tag, ".wb_alu_en"}, 32'(alu_en), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        dec_alu_en = 1'b0; dec_write_en = 1'b0; dec_halt = 1'b0; dec_br_op = 2'b00;
        alu_zero = 1'b0; alu_carry = 1'b0;
        step_mode = 1'b0; step_pulse = 1'b0; resume_pulse = 1'b0;

        tick();
        tick();
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.strobes", {26'd0, ir_load, alu_en, write_en, pc_en, pc_overwrite, halted}, 32'd0);
        chk("reset.retired", 32'(retired), 32'd0);
        rst_n = 1'b1;
        chk("idle.state", 32'(state), 32'd0);
        tick();

        // three ALU NOPs, 4 cycles each
        run_instr("nop1", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        run_instr("nop2", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        run_instr("nop3", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("run.retired3", 32'(retired), 32'd3);

        // flag latching and branches
        run_instr("alu_z1", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        run_instr("jz_taken", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        run_instr("alu_c1", 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        run_instr("jz_not", 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        run_instr("jc_latched", 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        run_instr("jmp", 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("run.retired9", 32'(retired), 32'd9);

        // HALT
        dec_alu_en = 1'b0; dec_write_en = 1'b1; dec_br_op = 2'b01; dec_halt = 1'b1;
        tick();
        chk("halt.decode", 32'(state), 32'd2);
        tick();
        chk("halt.state", 32'(state), 32'd6);
        chk("halt.halted", 32'(halted), 32'd1);
        for (int i = 0; i < 100; i++) begin
            step_pulse = (i == 40);
            tick();
            chk("halt.hold", {25'd0, state, ir_load, alu_en, write_en, pc_en, pc_overwrite},
                {25'd0, 3'd6, 5'd0});
        end
        step_pulse = 1'b0;
        chk("halt.retired", 32'(retired), 32'd9);
        resume_pulse = 1'b1; step_pulse = 1'b1;
        tick();
        resume_pulse = 1'b0; step_pulse = 1'b0; dec_halt = 1'b0;
        chk("resume.pc_en", 32'(pc_en), 32'd1);
        chk("resume.overwrite", 32'(pc_overwrite), 32'd0);
        chk("resume.write_en", 32'(write_en), 32'd0);
        tick();
        chk("resume.fetch", 32'(state), 32'd1);
        chk("resume.halted", 32'(halted), 32'd0);

        // single-step
        step_mode = 1'b1;
        run_instr("step1", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("step.park", 32'(state), 32'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("step.wait", {28'd0, state, pc_en}, {28'd0, 3'd5, 1'b0});
        end
        chk("step.retired10", 32'(retired), 32'd10);
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        run_instr("step2", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("step.park2", 32'(state), 32'd5);
        chk("step.retired11", 32'(retired), 32'd11);
        chk("cnt4.retired11", 32'(w4_retired), 32'd11);
        step_mode = 1'b0;
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;

        // six more ALU ops (flags -> Z=1, C=1): 17 total
        for (int i = 0; i < 6; i++) begin
            run_instr("alu_zc", 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("run.retired17", 32'(retired), 32'd17);
        chk("cnt4.saturate", 32'(w4_retired), 32'd15);

        // reset during EXECUTE
        dec_alu_en = 1'b1; dec_write_en = 1'b1; dec_br_op = 2'b00;
        tick();
        tick();
        chk("rst.pre_exec", {28'd0, state, alu_en}, {28'd0, 3'd3, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.strobes", {26'd0, ir_load, alu_en, write_en, pc_en, pc_overwrite, halted}, 32'd0);
        chk("rst.retired", 32'(retired), 32'd0);
        chk("rst.retired4", 32'(w4_retired), 32'd0);
        tick();
        chk("rst.hold", {28'd0, state, pc_en}, 32'd0);
        rst_n = 1'b1;
        tick();
        // flags were cleared by reset: JC with live carry=1 must not be taken
        run_instr("jc_after_rst", 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rst.retired1", 32'(retired), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
